// File: rtl/uart_sim_transmitter.sv
// Simulation-side UART transmitter: queues bytes through a small FIFO and
// serializes them as 8N1 / 8N2 frames, LSB first, at CLOCK_FREQ/BAUD_RATE cycles per bit.
module uart_sim_transmitter #(
    parameter int BAUD_RATE  = 19200,
    parameter int CLOCK_FREQ = 100000000,
    parameter int FIFO_DEPTH = 4,
    parameter int STOP_BITS  = 1
) (
    input  logic       clk_i,
    input  logic       rstn_i,
    input  logic [7:0] data_i,
    input  logic       valid_i,
    output logic       ready_o,
    output logic       txd_o,
    output logic       busy_o,
    output logic       done_o
);

    localparam int BAUD_VAL = CLOCK_FREQ / BAUD_RATE;
    localparam int PTR_W    = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CNT_W    = $clog2(((STOP_BITS > 1) ? STOP_BITS : 1) * ((BAUD_VAL > 1) ? BAUD_VAL : 2) + 1);
    localparam logic [CNT_W-1:0] BIT_RELOAD  = CNT_W'(BAUD_VAL - 1);
    localparam logic [CNT_W-1:0] STOP_RELOAD = CNT_W'(STOP_BITS * BAUD_VAL - 1);
    localparam logic [PTR_W:0]   FULL_COUNT  = (PTR_W + 1)'(FIFO_DEPTH);

    if (BAUD_VAL < 2) begin : g_bad_baud
        $error("uart_sim_transmitter: CLOCK_FREQ/BAUD_RATE must be at least 2");
    end
    if (STOP_BITS != 1 && STOP_BITS != 2) begin : g_bad_stop
        $error("uart_sim_transmitter: STOP_BITS must be 1 or 2");
    end
    if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
        $error("uart_sim_transmitter: FIFO_DEPTH must be a power of two >= 2");
    end

    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } state_t;

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  baud_cnt_q, baud_cnt_d;
    logic [2:0]        bit_cnt_q, bit_cnt_d;
    logic [7:0]        shift_q, shift_d;
    logic              txd_q, txd_d;

    logic [7:0]        mem_q [FIFO_DEPTH];
    logic [7:0]        mem_d [FIFO_DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [PTR_W:0]    count_q, count_d;

    logic              fifo_full;
    logic              fifo_empty;
    logic              push;
    logic              pop;
    logic              frame_done;

    assign fifo_full  = (count_q == FULL_COUNT);
    assign fifo_empty = (count_q == '0);
    assign push       = valid_i && !fifo_full;

    assign ready_o = !fifo_full;
    assign txd_o   = txd_q;
    assign busy_o  = (state_q != IDLE) || !fifo_empty;
    assign done_o  = frame_done;

    // Bit sequencer: every bit period counts down from BAUD_VAL-1; the stop
    // period is one longer count so 8N2 needs no extra state.
    always_comb begin
        state_d    = state_q;
        baud_cnt_d = baud_cnt_q;
        bit_cnt_d  = bit_cnt_q;
        shift_d    = shift_q;
        txd_d      = txd_q;
        pop        = 1'b0;
        frame_done = 1'b0;

        case (state_q)
            IDLE: begin
                txd_d = 1'b1;
                if (!fifo_empty) begin
                    pop        = 1'b1;
                    shift_d    = mem_q[rd_ptr_q];
                    txd_d      = 1'b0;
                    baud_cnt_d = BIT_RELOAD;
                    state_d    = START;
                end
            end
            START: begin
                if (baud_cnt_q == '0) begin
                    txd_d      = shift_q[0];
                    bit_cnt_d  = 3'd7;
                    baud_cnt_d = BIT_RELOAD;
                    state_d    = DATA;
                end else begin
                    baud_cnt_d = baud_cnt_q - 1'b1;
                end
            end
            DATA: begin
                if (baud_cnt_q == '0) begin
                    if (bit_cnt_q != 3'd0) begin
                        shift_d    = {1'b0, shift_q[7:1]};
                        txd_d      = shift_q[1];
                        bit_cnt_d  = bit_cnt_q - 3'd1;
                        baud_cnt_d = BIT_RELOAD;
                    end else begin
                        txd_d      = 1'b1;
                        baud_cnt_d = STOP_RELOAD;
                        state_d    = STOP;
                    end
                end else begin
                    baud_cnt_d = baud_cnt_q - 1'b1;
                end
            end
            STOP: begin
                if (baud_cnt_q == '0) begin
                    frame_done = 1'b1;
                    // Chain straight into the next start bit so queued bytes go out gap-free.
                    if (!fifo_empty) begin
                        pop        = 1'b1;
                        shift_d    = mem_q[rd_ptr_q];
                        txd_d      = 1'b0;
                        baud_cnt_d = BIT_RELOAD;
                        state_d    = START;
                    end else begin
                        state_d    = IDLE;
                    end
                end else begin
                    baud_cnt_d = baud_cnt_q - 1'b1;
                end
            end
            default: begin
                txd_d   = 1'b1;
                state_d = IDLE;
            end
        endcase
    end

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push) begin
            mem_d[wr_ptr_q] = data_i;
            wr_ptr_d        = wr_ptr_q + 1'b1;
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        case ({push, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            state_q    <= IDLE;
            baud_cnt_q <= '0;
            bit_cnt_q  <= '0;
            shift_q    <= '0;
            txd_q      <= 1'b1;
            mem_q      <= '{default: '0};
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
        end else begin
            state_q    <= state_d;
            baud_cnt_q <= baud_cnt_d;
            bit_cnt_q  <= bit_cnt_d;
            shift_q    <= shift_d;
            txd_q      <= txd_d;
            mem_q      <= mem_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
        end
    end

endmodule

// File: doc/uart_sim_transmitter.md
Name: uart_sim_transmitter

Overview:
- Simulation/test-bench UART transmitter producing 8N1 (optionally 8N2) frames on a serial line.
- Sits in the sim environment to drive the DUT's UART RX pin.
- Bytes are queued through a valid/ready handshake into a small FIFO and serialized LSB-first at a fixed baud rate.
- Pairs with the existing simulation UART receiver for loopback self-checks.

Parameters:
- BAUD_RATE, 19200, target baud rate in baud.
- CLOCK_FREQ, 100000000, frequency of clk_i in Hz.
- FIFO_DEPTH, 4, byte FIFO entries; power of two, >= 2.
- STOP_BITS, 1, number of stop bits; only 1 or 2 are legal.

Ports:
- clk_i  input  1  clock; all logic on the rising edge.
- rstn_i  input  1  reset; asynchronous, active-low.
- data_i  input  8  byte to transmit.
- valid_i  input  1  data_i valid.
- ready_o  output  1  FIFO can accept a byte (= not full).
- txd_o  output  1  UART serial output, idle high.
- busy_o  output  1  frame in progress or FIFO non-empty.
- done_o  output  1  one-cycle pulse at the end of each frame's stop period.

Behaviour:
- BAUD_VAL = CLOCK_FREQ / BAUD_RATE (integer division). Every bit (start, data, stop) is held for exactly BAUD_VAL cycles.
- Reset (rstn_i low, asynchronous):
  - FIFO emptied, state IDLE, counters cleared.
  - txd_o=1 (registered), busy_o=0, done_o=0, ready_o=1.
- Handshake:
  - Push occurs on the rising edge where valid_i && ready_o.
  - ready_o = !full, combinational from the FIFO pointers.
  - Push while full is ignored and the byte is lost; ready_o=0 tells the bench to hold.
  - Simultaneous push and pop is allowed whenever not full.
  - Pointers wrap modulo FIFO_DEPTH. Occupancy counter is clog2(FIFO_DEPTH)+1 bits.
- FSM states: IDLE, START, DATA, STOP.
- IDLE:
  - txd_o=1.
  - If FIFO non-empty: pop the head into the 8-bit shift register, drive txd_o=0 from the next edge, load the baud counter with BAUD_VAL-1, go to START.
  - Latency: a byte pushed at edge N into an empty idle block pops at edge N+1, so txd_o falls after edge N+1.
- START:
  - Baud counter decrements each cycle.
  - At 0: txd_o = shift register bit 0, bit counter = 7, reload BAUD_VAL-1, go to DATA.
- DATA:
  - At baud counter 0:
    - If bit counter > 0: shift right, output the next LSB, decrement bit counter, reload.
    - If bit counter = 0: txd_o=1, load the stop counter with STOP_BITS*BAUD_VAL-1, go to STOP.
- STOP:
  - At counter 0, done_o=1 for exactly that one cycle.
  - If the FIFO is non-empty, pop and enter START directly with txd_o=0 on the next edge. There is no extra idle cycle between frames.
  - Otherwise go to IDLE.
- Frame length: exactly (9+STOP_BITS)*BAUD_VAL cycles from the txd_o falling edge to the earliest possible next falling edge.
- busy_o = (state != IDLE) || (FIFO non-empty); registered or combinational is acceptable as long as it is glitch-free at sampling edges.
- Reset mid-frame:
  - txd_o returns to 1 immediately (asynchronously).
  - The partial frame and all FIFO contents are discarded.
  - No done_o pulse is generated.
- The receiver side must see the start bit as a clean 1->0 transition; txd_o is never X after reset.
- Elaboration: $error/$fatal if BAUD_VAL < 2, if STOP_BITS is not 1 or 2, or if FIFO_DEPTH is not a power of two.

Test Plan:
- Single byte: CLOCK_FREQ=16, BAUD_RATE=2 (BAUD_VAL=8), push 0x55 -> txd_o falls 1 cycle after push and holds each bit for 8 cycles. Pattern is 0,1,0,1,0,1,0,1,0,1. done_o pulses once, 80 cycles after the falling edge. busy_o drops after that.
- Loopback: connect txd_o to the simulation UART receiver (same BAUD_RATE/CLOCK_FREQ) and send "Hi!\n" -> receiver reports 0x48, 0x69, 0x21, 0x0A in order with valid pulses, and the console prints "Hi!".
- Back-to-back/FIFO full: FIFO_DEPTH=4, push 6 bytes with valid_i held high -> ready_o=0 once 4 bytes are queued behind the active frame. All 6 bytes are sent in order with no idle gap (next start bit immediately follows the stop bit). done_o pulses 6 times.
- STOP_BITS=2: push 0xA3 -> stop period is high for 2*BAUD_VAL cycles and the frame totals 11*BAUD_VAL cycles. Data bits LSB-first: 1,1,0,0,0,1,0,1.
- Reset mid-frame: assert rstn_i low during data bit 3 with 2 bytes queued -> txd_o=1 immediately and busy_o=0. No done_o pulse. After release the line stays idle high until a new push, and the first new byte is transmitted correctly.
- Push-while-full ignored: force valid_i with ready_o=0 for 3 cycles using data 0xFF -> 0xFF never appears on txd_o. Queued bytes are unaffected.
